// File: rtl/fix_mac_accum.sv
// Fixed-point MAC reduction stage: sums a packet of signed products plus a bias in a wide
// saturating accumulator, then rounds, clamps and optionally rectifies to WIDTH bits.
module fix_mac_accum #(
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned POINT_WIDTH = 8,
   parameter int unsigned ACC_WIDTH   = 40,
   parameter bit          RELU        = 1'b0
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [2*WIDTH-1:0]   in_p_i,
   input  logic                 in_last_i,
   input  logic [WIDTH-1:0]     in_bias_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [WIDTH-1:0]     out_data_o,
   output logic                 out_sat_o,
   output logic                 out_acc_ovf_o,
   output logic [15:0]          out_cnt_o
);

   typedef enum logic [1:0] {StAcc, StFin, StOut} state_e;

   localparam logic signed [ACC_WIDTH-1:0] AccMax = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] AccMin = {1'b1, {(ACC_WIDTH-1){1'b0}}};
   localparam logic signed [ACC_WIDTH:0]   RndHalf = (ACC_WIDTH+1)'(1) << (POINT_WIDTH-1);
   localparam logic [WIDTH-1:0]            ResMax = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0]            ResMin = {1'b1, {(WIDTH-1){1'b0}}};

   state_e state_q, state_d;

   logic signed [ACC_WIDTH-1:0] acc_q, base, bias_ext, acc_sat;
   logic signed [ACC_WIDTH:0]   sum, rnd_d, rnd_q;
   logic                        first_q, ovf_q, fin_phase_q, acc_ovf, accept;
   logic [15:0]                 cnt_q;
   logic [ACC_WIDTH:WIDTH-1]    rnd_upper;
   logic                        res_fits;
   logic [WIDTH-1:0]            res_val;
   logic [WIDTH-1:0]            out_data_q;
   logic                        out_sat_q, out_acc_ovf_q;
   logic [15:0]                 out_cnt_q;

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StAcc;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StAcc:   if (accept && in_last_i) state_d = StFin;
         StFin:   if (fin_phase_q) state_d = StOut;
         StOut:   if (out_ready_i) state_d = StAcc;
         default: state_d = StAcc;
      endcase
   end

   // Outputs decoded from state only; out_ready never reaches in_ready
   always_comb begin
      in_ready_o  = (state_q == StAcc) && !rst_i;
      out_valid_o = (state_q == StOut);
   end

   assign accept = in_valid_i && in_ready_o;

   always_comb begin
      bias_ext = ACC_WIDTH'($signed(in_bias_i)) <<< POINT_WIDTH;
      base     = first_q ? bias_ext : acc_q;
      sum      = (ACC_WIDTH+1)'(base) + (ACC_WIDTH+1)'($signed(in_p_i));
      acc_ovf  = sum[ACC_WIDTH] != sum[ACC_WIDTH-1];
      acc_sat  = acc_ovf ? (sum[ACC_WIDTH] ? AccMin : AccMax) : sum[ACC_WIDTH-1:0];
      rnd_d    = ((ACC_WIDTH+1)'(acc_q) + RndHalf) >>> POINT_WIDTH;
   end

   // Clamp and rectify operate on the registered rounded value
   always_comb begin
      rnd_upper = rnd_q[ACC_WIDTH:WIDTH-1];
      res_fits  = (&rnd_upper) || !(|rnd_upper);
      if (res_fits) begin
         res_val = rnd_q[WIDTH-1:0];
      end else begin
         res_val = rnd_q[ACC_WIDTH] ? ResMin : ResMax;
      end
      if (RELU && res_val[WIDTH-1]) begin
         res_val = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         acc_q         <= '0;
         first_q       <= 1'b1;
         ovf_q         <= 1'b0;
         cnt_q         <= '0;
         fin_phase_q   <= 1'b0;
         rnd_q         <= '0;
         out_data_q    <= '0;
         out_sat_q     <= 1'b0;
         out_acc_ovf_q <= 1'b0;
         out_cnt_q     <= '0;
      end else begin
         if (accept) begin
            acc_q   <= acc_sat;
            first_q <= 1'b0;
            ovf_q   <= ovf_q || acc_ovf;
            cnt_q   <= cnt_q + 16'd1;
         end
         if (state_q == StFin) begin
            fin_phase_q <= !fin_phase_q;
            if (!fin_phase_q) begin
               rnd_q <= rnd_d;
            end else begin
               out_data_q    <= res_val;
               out_sat_q     <= !res_fits;
               out_acc_ovf_q <= ovf_q;
               out_cnt_q     <= cnt_q;
            end
         end
         if (state_q == StOut && out_ready_i) begin
            acc_q   <= '0;
            first_q <= 1'b1;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
         end
      end
   end

   assign out_data_o    = out_data_q;
   assign out_sat_o     = out_sat_q;
   assign out_acc_ovf_o = out_acc_ovf_q;
   assign out_cnt_o     = out_cnt_q;

endmodule

// File: tb/tb_fix_mac_accum.sv
// Bench for fix_mac_accum: three instances (default, ReLU, 34-bit accumulator) share one
// stimulus stream; results are compared against a plain-arithmetic packet model.
module tb_fix_mac_accum;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_last, out_ready;
   logic [31:0] in_p;
   logic [15:0] in_bias;

   logic        a_in_ready, a_out_valid, a_out_sat, a_out_ovf;
   logic [15:0] a_out_data, a_out_cnt;
   logic        r_in_ready, r_out_valid, r_out_sat, r_out_ovf;
   logic [15:0] r_out_data, r_out_cnt;
   logic        s_in_ready, s_out_valid, s_out_sat, s_out_ovf;
   logic [15:0] s_out_data, s_out_cnt;

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   fix_mac_accum #(.WIDTH(16), .POINT_WIDTH(8), .ACC_WIDTH(40), .RELU(1'b0)) u_dut_a (
      .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(a_in_ready),
      .in_p_i(in_p), .in_last_i(in_last), .in_bias_i(in_bias), .out_valid_o(a_out_valid),
      .out_ready_i(out_ready), .out_data_o(a_out_data), .out_sat_o(a_out_sat),
      .out_acc_ovf_o(a_out_ovf), .out_cnt_o(a_out_cnt)
   );

   fix_mac_accum #(.WIDTH(16), .POINT_WIDTH(8), .ACC_WIDTH(40), .RELU(1'b1)) u_dut_r (
      .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(r_in_ready),
      .in_p_i(in_p), .in_last_i(in_last), .in_bias_i(in_bias), .out_valid_o(r_out_valid),
      .out_ready_i(out_ready), .out_data_o(r_out_data), .out_sat_o(r_out_sat),
      .out_acc_ovf_o(r_out_ovf), .out_cnt_o(r_out_cnt)
   );

   fix_mac_accum #(.WIDTH(16), .POINT_WIDTH(8), .ACC_WIDTH(34), .RELU(1'b0)) u_dut_s (
      .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(s_in_ready),
      .in_p_i(in_p), .in_last_i(in_last), .in_bias_i(in_bias), .out_valid_o(s_out_valid),
      .out_ready_i(out_ready), .out_data_o(s_out_data), .out_sat_o(s_out_sat),
      .out_acc_ovf_o(s_out_ovf), .out_cnt_o(s_out_cnt)
   );

   // Packet result from the arithmetic rules: saturating running sum, round, clamp, ReLU
   function automatic void model(input logic [15:0] bias, input longint prods[$],
                                 input int accw, input bit relu, output logic [15:0] data,
                                 output bit sat, output bit ovf);
      longint acc, mx, mn, r;
      mx  = (longint'(1) <<< (accw - 1)) - 1;
      mn  = -mx - 1;
      acc = longint'($signed(bias)) * 256;
      ovf = 1'b0;
      foreach (prods[i]) begin
         acc = acc + prods[i];
         if (acc > mx) begin acc = mx; ovf = 1'b1; end
         else if (acc < mn) begin acc = mn; ovf = 1'b1; end
      end
      r   = (acc + 128) >>> 8;
      sat = 1'b0;
      if (r > 32767) begin r = 32767; sat = 1'b1; end
      else if (r < -32768) begin r = -32768; sat = 1'b1; end
      if (relu && r < 0) r = 0;
      data = r[15:0];
   endfunction

   function automatic longint rand_prod();
      if ($urandom_range(1) == 1) return longint'($signed(32'($urandom)));
      return longint'($urandom_range(2097151)) - 64'sd1048576;
   endfunction

   // Drives one packet; lat = edges from last-beat acceptance to out_valid (capped)
   task automatic run_packet(input logic [15:0] bias, input longint prods[$],
                             input int bubble_pct, output int lat);
      int     w;
      longint v;
      for (int i = 0; i < prods.size(); i++) begin
         while ($urandom_range(99) < bubble_pct) begin
            in_valid = 1'b0;
            in_bias  = 16'($urandom);
            @(negedge clk);
         end
         v        = prods[i];
         in_valid = 1'b1;
         in_p     = v[31:0];
         in_last  = (i == prods.size() - 1);
         in_bias  = (i == 0) ? bias : 16'($urandom);
         w = 0;
         while (!a_in_ready && w < 10) begin @(negedge clk); w++; end
         @(negedge clk);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_p     = $urandom;
      lat = 0;
      while (!a_out_valid && lat < 20) begin @(negedge clk); lat++; end
   endtask

   task automatic ack();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
      in_p = '0; in_bias = '0;
      repeat (3) @(negedge clk);
      vectors++;
      if ({a_in_ready, r_in_ready, s_in_ready} !== 3'b000)
         $display("FAIL reset_in_ready: got %b expected 000", {a_in_ready, r_in_ready, s_in_ready});
      vectors++;
      if ({a_out_valid, a_out_data, a_out_sat, a_out_ovf, a_out_cnt} !== 35'h0)
         $display("FAIL reset_outputs: got v%b d%h s%b o%b c%h expected all zero",
                  a_out_valid, a_out_data, a_out_sat, a_out_ovf, a_out_cnt);
      if ({a_out_valid, a_out_data, a_out_sat, a_out_ovf, a_out_cnt} !== 35'h0) errors++;
      if ({a_in_ready, r_in_ready, s_in_ready} !== 3'b000) errors++;
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if (a_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_reset: got %b expected 1", a_in_ready);
      end
   endtask

   task automatic test_basic();
      longint q[$];
      int     lat;
      q.push_back(64'h10000);
      q.push_back(64'h20000);
      run_packet(16'h0080, q, 0, lat);
      vectors++;
      if (lat != 2) begin errors++; $display("FAIL basic_latency: got %0d expected 2", lat); end
      vectors++;
      if (a_out_data !== 16'h0380 || a_out_cnt !== 16'd2 || a_out_sat !== 1'b0 ||
          a_out_ovf !== 1'b0) begin
         errors++;
         $display("FAIL basic_result: got d%h c%0d s%b o%b expected d0380 c2 s0 o0",
                  a_out_data, a_out_cnt, a_out_sat, a_out_ovf);
      end
      ack();
      vectors++;
      if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_handshake: got rdy%b vld%b expected rdy1 vld0",
                  a_in_ready, a_out_valid);
      end
   endtask

   task automatic test_rounding();
      logic [31:0] pv[3] = '{32'h00000080, 32'hFFFFFF80, 32'hFFFFFF7F};
      logic [15:0] ev[3] = '{16'h0001, 16'h0000, 16'hFFFF};
      longint      q[$];
      int          lat;
      for (int i = 0; i < 3; i++) begin
         q.delete();
         q.push_back(longint'($signed(pv[i])));
         run_packet(16'h0000, q, 0, lat);
         vectors++;
         if (a_out_data !== ev[i] || a_out_cnt !== 16'd1 || lat != 2) begin
            errors++;
            $display("FAIL rounding_%0d: got d%h c%0d lat%0d expected d%h c1 lat2",
                     i, a_out_data, a_out_cnt, lat, ev[i]);
         end
         ack();
      end
   endtask

   task automatic test_saturation();
      longint q[$];
      int     lat;
      q = '{64'h7FFF0000, 64'h7FFF0000};
      run_packet(16'h0000, q, 0, lat);
      vectors++;
      if (a_out_data !== 16'h7FFF || a_out_sat !== 1'b1 || a_out_ovf !== 1'b0 ||
          s_out_data !== 16'h7FFF || s_out_ovf !== 1'b0) begin
         errors++;
         $display("FAIL sat_pos: got d%h s%b o%b small d%h o%b expected d7fff s1 o0",
                  a_out_data, a_out_sat, a_out_ovf, s_out_data, s_out_ovf);
      end
      ack();
      q = '{-64'sh80000000, -64'sh80000000};
      run_packet(16'h0000, q, 0, lat);
      vectors++;
      if (a_out_data !== 16'h8000 || a_out_sat !== 1'b1) begin
         errors++;
         $display("FAIL sat_neg: got d%h s%b expected d8000 s1", a_out_data, a_out_sat);
      end
      vectors++;
      if (r_out_data !== 16'h0000 || r_out_sat !== 1'b1) begin
         errors++;
         $display("FAIL sat_neg_relu: got d%h s%b expected d0000 s1", r_out_data, r_out_sat);
      end
      ack();
   endtask

   task automatic test_acc_ovf();
      longint q[$];
      int     lat;
      for (int i = 0; i < 6; i++) q.push_back(64'h7FFF0000);
      run_packet(16'h0000, q, 0, lat);
      vectors++;
      if (s_out_ovf !== 1'b1 || s_out_data !== 16'h7FFF || s_out_sat !== 1'b1 ||
          s_out_cnt !== 16'd6) begin
         errors++;
         $display("FAIL acc_ovf_small: got o%b d%h s%b c%0d expected o1 d7fff s1 c6",
                  s_out_ovf, s_out_data, s_out_sat, s_out_cnt);
      end
      vectors++;
      if (a_out_ovf !== 1'b0 || a_out_data !== 16'h7FFF) begin
         errors++;
         $display("FAIL acc_ovf_wide: got o%b d%h expected o0 d7fff", a_out_ovf, a_out_data);
      end
      ack();
   endtask

   task automatic test_backpressure();
      longint      q[$];
      logic [15:0] bias, ed;
      bit          es, eo;
      int          lat;
      bias = 16'($urandom);
      for (int i = 0; i < 4; i++) q.push_back(rand_prod());
      model(bias, q, 40, 1'b0, ed, es, eo);
      run_packet(bias, q, 0, lat);
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1; in_last = 1'b1; in_p = $urandom; in_bias = 16'($urandom);
         vectors++;
         if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0 || a_out_data !== ed ||
             a_out_sat !== es || a_out_ovf !== eo) begin
            errors++;
            $display("FAIL hold_%0d: got v%b r%b d%h s%b o%b expected v1 r0 d%h s%b o%b", k,
                     a_out_valid, a_in_ready, a_out_data, a_out_sat, a_out_ovf, ed, es, eo);
         end
         @(negedge clk);
      end
      in_valid = 1'b0; in_last = 1'b0;
      ack();
      vectors++;
      if (a_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL release_ready: got %b expected 1", a_in_ready);
      end
      q.delete();
      bias = 16'($urandom);
      for (int i = 0; i < 3; i++) q.push_back(rand_prod());
      model(bias, q, 40, 1'b0, ed, es, eo);
      run_packet(bias, q, 0, lat);
      vectors++;
      if (a_out_data !== ed || a_out_cnt !== 16'd3 || lat != 2) begin
         errors++;
         $display("FAIL back_to_back: got d%h c%0d lat%0d expected d%h c3 lat2",
                  a_out_data, a_out_cnt, lat, ed);
      end
      ack();
   endtask

   task automatic test_bubbles();
      longint      q[$];
      logic [15:0] bias, ed;
      bit          es, eo;
      int          lat, n;
      for (int p = 0; p < 4; p++) begin
         q.delete();
         n    = $urandom_range(8, 3);
         bias = 16'($urandom);
         for (int i = 0; i < n; i++) q.push_back(rand_prod());
         model(bias, q, 40, 1'b0, ed, es, eo);
         run_packet(bias, q, 40, lat);
         vectors++;
         if (a_out_data !== ed || a_out_sat !== es || a_out_ovf !== eo ||
             a_out_cnt !== 16'(n) || lat != 2) begin
            errors++;
            $display("FAIL bubbles_%0d: got d%h s%b o%b c%0d lat%0d expected d%h s%b o%b c%0d",
                     p, a_out_data, a_out_sat, a_out_ovf, a_out_cnt, lat, ed, es, eo, n);
         end
         ack();
      end
   endtask

   task automatic test_reset_mid();
      longint q[$];
      int     lat;
      bit     seen;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_last = 1'b0; in_p = 32'h00400000; in_bias = 16'h1234;
         @(negedge clk);
      end
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (a_out_valid !== 1'b0) seen = 1'b1;
         @(negedge clk);
      end
      vectors++;
      if (seen) begin errors++; $display("FAIL reset_mid_no_output: got valid expected none"); end
      q.push_back(64'h10000);
      run_packet(16'h0000, q, 0, lat);
      vectors++;
      if (a_out_data !== 16'h0100 || a_out_cnt !== 16'd1 || a_out_ovf !== 1'b0) begin
         errors++;
         $display("FAIL after_reset_pkt: got d%h c%0d o%b expected d0100 c1 o0",
                  a_out_data, a_out_cnt, a_out_ovf);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      vectors++;
      if (a_out_valid !== 1'b0 || a_out_data !== 16'h0 || a_out_cnt !== 16'h0) begin
         errors++;
         $display("FAIL reset_in_out: got v%b d%h c%0d expected v0 d0000 c0",
                  a_out_valid, a_out_data, a_out_cnt);
      end
   endtask

   task automatic test_random();
      longint      q[$];
      logic [15:0] bias, ea, er, es_d;
      bit          sa, oa, sr, orr, ss, os;
      int          lat, n;
      for (int p = 0; p < 40; p++) begin
         q.delete();
         n    = $urandom_range(8, 1);
         bias = 16'($urandom);
         for (int i = 0; i < n; i++) q.push_back(rand_prod());
         model(bias, q, 40, 1'b0, ea, sa, oa);
         model(bias, q, 40, 1'b1, er, sr, orr);
         model(bias, q, 34, 1'b0, es_d, ss, os);
         run_packet(bias, q, 20, lat);
         vectors++;
         if (a_out_data !== ea || a_out_sat !== sa || a_out_ovf !== oa ||
             a_out_cnt !== 16'(n) || lat != 2) begin
            errors++;
            $display("FAIL random_a_%0d: got d%h s%b o%b c%0d lat%0d expected d%h s%b o%b c%0d",
                     p, a_out_data, a_out_sat, a_out_ovf, a_out_cnt, lat, ea, sa, oa, n);
         end
         vectors++;
         if (r_out_data !== er || r_out_sat !== sr || r_out_ovf !== orr) begin
            errors++;
            $display("FAIL random_relu_%0d: got d%h s%b o%b expected d%h s%b o%b",
                     p, r_out_data, r_out_sat, r_out_ovf, er, sr, orr);
         end
         vectors++;
         if (s_out_data !== es_d || s_out_sat !== ss || s_out_ovf !== os ||
             s_out_cnt !== 16'(n)) begin
            errors++;
            $display("FAIL random_acc34_%0d: got d%h s%b o%b c%0d expected d%h s%b o%b c%0d",
                     p, s_out_data, s_out_sat, s_out_ovf, s_out_cnt, es_d, ss, os, n);
         end
         ack();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_rounding();
      test_saturation();
      test_acc_ovf();
      test_backpressure();
      test_bubbles();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
